// File: rtl/nios_dbg_ocimem_pkg.sv
// Shared types and constants for the debug on-chip memory controller.
package nios_dbg_ocimem_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BE_W         = 4;
    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_ADDR_LSB = 26;
    localparam int unsigned JDO_CLR_BIT  = 25;
    localparam int unsigned JDO_DATA_LSB = 3;

    typedef enum logic [2:0] {
        IDLE,
        JWR,
        JRD,
        JRD_CAP,
        AVRD
    } ocimem_state_e;

    // Write half of a RAM request; the address travels separately because its width is a parameter.
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] wdata;
    } ram_wr_t;

endpackage

// File: rtl/nios_dbg_ocimem_ram.sv
// Single-port synchronous debug RAM, one-cycle read latency, byte-lane writes.
module nios_dbg_ocimem_ram
    import nios_dbg_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  ram_wr_t           wr,
    output logic [WORD_W-1:0] q
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents when addressing the word being written.
    always_ff @(posedge clk) begin
        if (wr.we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr.be[b]) begin
                    mem[addr][8*b +: 8] <= wr.wdata[8*b +: 8];
                end
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/nios_dbg_ocimem_ctrl.sv
// Debug RAM controller: arbitrates the monitor RAM between JTAG command strobes
// and the CPU's Avalon-MM debug_mem slave, and holds MonAReg/MonDReg/status.
module nios_dbg_ocimem_ctrl
    import nios_dbg_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    input  logic              debugaccess,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state, state_d;
    logic [ADDR_W-1:0] mon_areg;
    logic              pend_wr, pend_rd;
    logic [DATA_W-1:0] rd_hold;
    logic [ADDR_W-1:0] ram_addr;
    ram_wr_t           ram_wr;
    logic [DATA_W-1:0] ram_q;
    logic              avs_wr_done;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0]};

    nios_dbg_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .wr   (ram_wr),
        .q    (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Arbitration and RAM port steering; JTAG pending work outranks Avalon in IDLE.
    always_comb begin
        state_d         = state;
        ram_addr        = mon_areg;
        ram_wr          = '0;
        avs_wr_done     = 1'b0;
        avs_waitrequest = 1'b0;
        case (state)
            IDLE: begin
                if (pend_wr) begin
                    state_d = JWR;
                end else if (pend_rd) begin
                    state_d = JRD;
                end else if (avs_write) begin
                    ram_addr    = avs_address;
                    avs_wr_done = 1'b1;
                    if (debugaccess) begin
                        ram_wr.we    = 1'b1;
                        ram_wr.be    = avs_byteenable;
                        ram_wr.wdata = avs_writedata;
                    end
                end else if (avs_read) begin
                    ram_addr = avs_address;
                    state_d  = AVRD;
                end
            end
            JWR: begin
                ram_wr.we    = 1'b1;
                ram_wr.be    = '1;
                ram_wr.wdata = MonDReg;
                state_d      = IDLE;
            end
            JRD:     state_d = JRD_CAP;
            JRD_CAP: state_d = IDLE;
            AVRD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A write must never land once reset has begun.
        ram_wr.we       = ram_wr.we & reset_n;
        avs_waitrequest = (avs_read | avs_write)
                        & ~(avs_wr_done | ((state == AVRD) & avs_read));
    end

    assign avs_readdata = (state == AVRD) ? ram_q : rd_hold;

    // Monitor registers; strobe effects follow FSM effects so a load overrides an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            pend_wr       <= 1'b0;
            pend_rd       <= 1'b0;
            rd_hold       <= '0;
        end else begin
            case (state)
                JWR: begin
                    mon_areg      <= mon_areg + ADDR_W'(1);
                    pend_wr       <= 1'b0;
                    monitor_ready <= 1'b1;
                end
                JRD: pend_rd <= 1'b0;
                JRD_CAP: begin
                    MonDReg       <= ram_q;
                    mon_areg      <= mon_areg + ADDR_W'(1);
                    monitor_ready <= 1'b1;
                end
                AVRD: rd_hold <= ram_q;
                default: ;
            endcase
            if (avs_wr_done && !debugaccess) begin
                monitor_error <= 1'b1;
            end
            if (take_action_ocimem_a) begin
                mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_CLR_BIT]) begin
                    monitor_ready <= 1'b0;
                    monitor_error <= 1'b0;
                end
            end
            if (take_action_ocimem_b) begin
                if (pend_wr) begin
                    monitor_error <= 1'b1;
                end else begin
                    MonDReg       <= jdo[JDO_DATA_LSB +: DATA_W];
                    pend_wr       <= 1'b1;
                    monitor_ready <= 1'b0;
                end
            end
            if (take_no_action_ocimem_a) begin
                if (pend_rd) begin
                    monitor_error <= 1'b1;
                end else begin
                    pend_rd       <= 1'b1;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
// Directed bench for nios_dbg_ocimem_ctrl with a transaction-level model of the
// monitor registers and debug RAM, compared against the DUT every cycle.
module tb_nios_dbg_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        debugaccess;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    always #5 clk = ~clk;

    nios_dbg_ocimem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .debugaccess             (debugaccess),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what the outputs must show after each edge.
    logic [31:0] m_mem [256];
    logic [7:0]  m_areg;
    logic [31:0] m_dreg, m_rdata;
    logic        m_ready, m_error, m_wait;
    bit          chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("MonDReg", MonDReg, m_dreg);
            cmp("monitor_ready", 32'(monitor_ready), 32'(m_ready));
            cmp("monitor_error", 32'(monitor_error), 32'(m_error));
            cmp("avs_waitrequest", 32'(avs_waitrequest), 32'(m_wait));
            cmp("avs_readdata", avs_readdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_addr(input logic [7:0] a, input logic clr);
        jdo = {4'b0, a, clr, 25'b0};
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        m_areg = a;
        if (clr) begin
            m_ready = 1'b0;
            m_error = 1'b0;
        end
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jdo = {3'b0, d, 3'b0};
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        m_dreg  = d;
        m_ready = 1'b0;
        tick();
        tick();
        m_mem[m_areg] = d;
        m_areg        = m_areg + 8'd1;
        m_ready       = 1'b1;
    endtask

    task automatic jtag_read();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        tick();
        m_dreg  = m_mem[m_areg];
        m_areg  = m_areg + 8'd1;
        m_ready = 1'b1;
    endtask

    task automatic avs_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        debugaccess    = dbg;
        avs_write      = 1'b1;
        tick();
        avs_write   = 1'b0;
        debugaccess = 1'b0;
        if (dbg) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end else begin
            m_error = 1'b1;
        end
    endtask

    task automatic avs_rd(input logic [7:0] a);
        avs_address = a;
        avs_read    = 1'b1;
        m_wait      = 1'b1;
        tick();
        m_wait  = 1'b0;
        m_rdata = m_mem[a];
        tick();
        avs_read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        debugaccess = 1'b0;
        m_areg = '0; m_dreg = '0; m_rdata = '0;
        m_ready = 1'b0; m_error = 1'b0; m_wait = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        cmp("rst_MonDReg", MonDReg, 32'h0);
        cmp("rst_ready", 32'(monitor_ready), 32'h0);
        cmp("rst_error", 32'(monitor_error), 32'h0);
        cmp("rst_readdata", avs_readdata, 32'h0);
        cmp("rst_wait", 32'(avs_waitrequest), 32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        // JTAG write then read-back, including address auto-increment.
        jtag_addr(8'h11, 1'b1);
        jtag_write(32'h5555_AAAA);
        jtag_addr(8'h10, 1'b0);
        jtag_write(32'hDEAD_BEEF);
        cmp("wr_ready", 32'(monitor_ready), 32'h1);
        jtag_addr(8'h10, 1'b0);
        jtag_read();
        cmp("rd_0x10", MonDReg, 32'hDEAD_BEEF);
        jtag_read();
        cmp("rd_inc_0x11", MonDReg, 32'h5555_AAAA);

        // Address wrap 0xFF -> 0x00.
        jtag_addr(8'h00, 1'b0);
        jtag_write(32'h0BAD_F00D);
        jtag_addr(8'hFF, 1'b0);
        jtag_write(32'h0000_0001);
        jtag_read();
        cmp("wrap_rd_0x00", MonDReg, 32'h0BAD_F00D);
        jtag_addr(8'hFF, 1'b0);
        jtag_read();
        cmp("rd_0xff", MonDReg, 32'h0000_0001);

        // Avalon writes with byte lanes, then reads.
        avs_wr(8'h20, 32'hA5A5_0020, 4'hF, 1'b1);
        avs_rd(8'h20);
        cmp("avs_rd_0x20", avs_readdata, 32'hA5A5_0020);
        avs_wr(8'h20, 32'hFFFF_FFFF, 4'b0010, 1'b1);
        avs_rd(8'h20);
        cmp("avs_be_0x20", avs_readdata, 32'hA5A5_FF20);

        // Contention: pending JTAG read beats an Avalon read that arrives next cycle.
        jtag_addr(8'h10, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        avs_address = 8'h20;
        avs_read    = 1'b1;
        m_ready     = 1'b0;
        m_wait      = 1'b1;
        tick();
        tick();
        tick();
        m_dreg  = m_mem[m_areg];
        m_areg  = m_areg + 8'd1;
        m_ready = 1'b1;
        tick();
        m_wait  = 1'b0;
        m_rdata = m_mem[8'h20];
        tick();
        avs_read = 1'b0;
        cmp("cont_jtag", MonDReg, 32'hDEAD_BEEF);
        cmp("cont_avs", avs_readdata, 32'hA5A5_FF20);

        // Unqualified Avalon write is dropped but flags an error; _a with clear resets it.
        avs_wr(8'h05, 32'hCAFE_F00D, 4'hF, 1'b1);
        avs_wr(8'h05, 32'h1234_5678, 4'hF, 1'b0);
        cmp("nodbg_error", 32'(monitor_error), 32'h1);
        avs_rd(8'h05);
        cmp("nodbg_unchanged", avs_readdata, 32'hCAFE_F00D);
        jtag_addr(8'h00, 1'b1);
        cmp("clr_error", 32'(monitor_error), 32'h0);

        // Second read strobe while one is pending is dropped and sets the error.
        jtag_addr(8'h10, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        take_no_action_ocimem_a = 1'b0;
        m_error = 1'b1;
        tick();
        tick();
        m_dreg  = m_mem[m_areg];
        m_areg  = m_areg + 8'd1;
        m_ready = 1'b1;
        cmp("drop_error", 32'(monitor_error), 32'h1);
        cmp("drop_rd", MonDReg, 32'hDEAD_BEEF);
        jtag_addr(8'h00, 1'b1);

        // Reset while in JRD_CAP.
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp("arst_MonDReg", MonDReg, 32'h0);
        cmp("arst_ready", 32'(monitor_ready), 32'h0);
        cmp("arst_error", 32'(monitor_error), 32'h0);
        cmp("arst_readdata", avs_readdata, 32'h0);
        m_areg = '0; m_dreg = '0; m_rdata = '0;
        m_ready = 1'b0; m_error = 1'b0; m_wait = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (4) tick();
        jtag_read();
        cmp("post_rst_rd_0x00", MonDReg, 32'h0BAD_F00D);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
